// File: rtl/serial_adder4.sv
// Bit-serial 4-bit unsigned adder: one full-adder slice plus a carry flop.
// Operands load in one cycle, bits sum LSB first, {cout, s} lands with a done pulse.
module serial_adder4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] s,
    output logic       cout,
    output logic       busy,
    output logic       done
);

    // One-hot codes; any other pattern falls back to IDLE.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RUN  = 3'b010,
        DONE = 3'b100
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [3:0] r_ra;
    logic [3:0] r_rb;
    logic [3:0] r_acc;
    logic [1:0] r_cnt;
    logic       r_c;
    logic [3:0] r_s;
    logic       r_cout;
    logic       r_busy;
    logic       r_done;

    logic       w_sum;
    logic       w_carry;
    logic       w_load;
    logic       w_last;

    assign w_sum   = r_ra[0] ^ r_rb[0] ^ r_c;
    assign w_carry = (r_ra[0] & r_rb[0]) | (r_ra[0] & r_c) | (r_rb[0] & r_c);
    assign w_last  = (r_cnt == 2'd3);

    always_comb begin
        w_state_nxt = IDLE;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                w_state_nxt = w_last ? DONE : RUN;
            end
            DONE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ra    <= 4'd0;
            r_rb    <= 4'd0;
            r_acc   <= 4'd0;
            r_cnt   <= 2'd0;
            r_c     <= 1'b0;
            r_s     <= 4'd0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == RUN);
            r_done  <= (w_state_nxt == DONE);
            if (w_load) begin
                r_ra  <= a;
                r_rb  <= b;
                r_acc <= 4'd0;
                r_cnt <= 2'd0;
                r_c   <= 1'b0;
            end else if (r_state == RUN) begin
                r_ra  <= {1'b0, r_ra[3:1]};
                r_rb  <= {1'b0, r_rb[3:1]};
                r_acc <= {w_sum, r_acc[3:1]};
                r_c   <= w_carry;
                r_cnt <= r_cnt + 2'd1;
                // Result registers only move on the final bit.
                if (w_last) begin
                    r_s    <= {w_sum, r_acc[3:1]};
                    r_cout <= w_carry;
                end
            end
        end
    end

    assign s    = r_s;
    assign cout = r_cout;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_serial_adder4.sv
// Self-checking bench for serial_adder4: vector table, scoreboard queue,
// handshake/reset corner sequences and an exhaustive sweep.
module tb_serial_adder4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       cout;
    logic       busy;
    logic       done;

    serial_adder4 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .s     (s),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] sum;
    } vec_t;

    vec_t       vecs[6];
    logic [4:0] q[$];
    int         n_pass;
    int         n_total;
    int         cyc;
    int         n_done;
    int         last_done_cyc;
    int         prev_done_cyc;
    logic       prev_done;
    logic       got_done;

    task automatic chk(input string name, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                      name, act, expv, cyc);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (done) begin
            got_done = 1'b1;
            n_done++;
            chk("busy_with_done", int'(busy), 0);
            chk("done_width", int'(prev_done), 0);
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else chk("result", int'({cout, s}), int'(q.pop_front()));
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
        end
        prev_done = done;
    endtask

    task automatic wait_done();
        got_done = 1'b0;
        for (int n = 0; n < 10 && !got_done; n++) cycle();
        if (!got_done) chk("done_timeout", 0, 1);
    endtask

    task automatic run_add(input logic [3:0] ia, input logic [3:0] ib);
        a     = ia;
        b     = ib;
        start = 1'b1;
        q.push_back(5'(ia) + 5'(ib));
        cycle();
        start = 1'b0;
        wait_done();
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        cyc = 0;
        n_done = 0;
        last_done_cyc = 0;
        prev_done_cyc = 0;
        prev_done = 1'b0;
        got_done = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        a = 4'd0;
        b = 4'd0;

        vecs[0] = '{4'd15, 4'd1,  5'd16};
        vecs[1] = '{4'd15, 4'd15, 5'd30};
        vecs[2] = '{4'd0,  4'd0,  5'd0};
        vecs[3] = '{4'd8,  4'd8,  5'd16};
        vecs[4] = '{4'd10, 4'd5,  5'd15};
        vecs[5] = '{4'd6,  4'd11, 5'd17};

        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_s", int'(s), 0);
        chk("rst_cout", int'(cout), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);

        // Basic add with busy window and result hold.
        a = 4'd5;
        b = 4'd9;
        start = 1'b1;
        q.push_back(5'd14);
        cycle();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("busy_window", int'(busy), 1);
            chk("no_early_done", int'(done), 0);
            if (i < 3) cycle();
        end
        cycle();
        chk("done_at_k4", int'(done), 1);
        chk("busy_at_k4", int'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("hold_s", int'(s), 14);
            chk("hold_cout", int'(cout), 0);
            chk("hold_done", int'(done), 0);
        end

        for (int i = 0; i < 6; i++) begin
            run_add(vecs[i].a, vecs[i].b);
            chk("vec_sum", int'({cout, s}), int'(vecs[i].sum));
            cycle();
        end

        // start during RUN is ignored.
        run_add(4'd2, 4'd2);
        a = 4'd2;
        b = 4'd2;
        start = 1'b1;
        q.push_back(5'd4);
        cycle();
        start = 1'b0;
        cycle();
        a = 4'd3;
        b = 4'd4;
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_done();
        chk("ignore_start_s", int'(s), 4);
        cycle();
        cycle();
        chk("ignore_start_idle", int'(busy), 0);

        // Back-to-back with start held; operands changed during RUN.
        a = 4'd2;
        b = 4'd2;
        start = 1'b1;
        q.push_back(5'd4);
        cycle();
        a = 4'd3;
        b = 4'd4;
        wait_done();
        q.push_back(5'd7);
        cycle();
        start = 1'b0;
        chk("b2b_busy", int'(busy), 1);
        wait_done();
        chk("b2b_s", int'(s), 7);
        chk("b2b_spacing", last_done_cyc - prev_done_cyc, 5);

        // Reset mid-operation aborts with cleared outputs.
        cycle();
        run_add(4'd1, 4'd1);
        cycle();
        a = 4'd7;
        b = 4'd8;
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("abort_s", int'(s), 0);
        chk("abort_cout", int'(cout), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        begin
            int nd;
            nd = n_done;
            for (int i = 0; i < 6; i++) cycle();
            chk("abort_no_done", n_done - nd, 0);
        end
        run_add(4'd7, 4'd8);
        chk("after_abort_s", int'(s), 15);
        chk("after_abort_cout", int'(cout), 0);

        // start coincident with reset is dropped.
        cycle();
        rst = 1'b1;
        start = 1'b1;
        cycle();
        rst = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", int'(busy), 0);
        cycle();
        chk("rst_start_busy2", int'(busy), 0);

        for (int i = 0; i < 256; i++) begin
            int gap;
            run_add(4'(i >> 4), 4'(i));
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) cycle();
        end

        cycle();
        cycle();
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
